// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: FSM state encoding, the time
// snapshot layout used by the display freeze and lap FIFO, and the saturation limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_STOP  = 2'd3
    } sw_state_t;

    // Packed MSB-first so a snapshot is directly the {minute, second, msecond} lap word.
    typedef struct packed {
        logic [7:0]  minute;
        logic [7:0]  second;
        logic [15:0] msecond;
    } snapshot_t;

    localparam logic [7:0] SAT_MINUTE = 8'd59;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debounce and a one-cycle
// pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          stable, stable_d;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            stable_d    <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= btn_in;
            sync2       <= sync1;
            stable_d    <= stable;
            press_pulse <= stable & ~stable_d;
            // The counter only advances while the synchronized level disagrees with the accepted one.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/split/stop sequencer with display freeze and an optional lap FIFO.
// Define STOPWATCH_CTRL_LAP_FIFO_EN to build the lap FIFO; otherwise lap outputs are tied to 0.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LAP_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_start,
    input  logic                        btn_lap,
    input  logic [7:0]                  t_minute,
    input  logic [7:0]                  t_second,
    input  logic [15:0]                 t_msecond,
    output logic                        timer_clear,
    output logic [7:0]                  disp_minute,
    output logic [7:0]                  disp_second,
    output logic [15:0]                 disp_msecond,
    output logic [1:0]                  state,
    output logic                        lap_valid,
    input  logic                        lap_ready,
    output logic [31:0]                 lap_data,
    output logic [$clog2(LAP_DEPTH):0]  lap_count,
    output logic                        lap_overflow
);

    logic      start_pulse, lap_pulse;
    logic      start_ev, lap_ev, saturated;
    logic      push_req, flush, load_disp;
    sw_state_t cur_state, next_state;
    snapshot_t snap, disp_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_start),
        .press_pulse (start_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_lap),
        .press_pulse (lap_pulse)
    );

    assign snap      = '{minute: t_minute, second: t_second, msecond: t_msecond};
    assign start_ev  = start_pulse;
    assign lap_ev    = lap_pulse & ~start_pulse;
    assign saturated = (t_minute == SAT_MINUTE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = cur_state;
        push_req   = 1'b0;
        flush      = 1'b0;
        load_disp  = 1'b0;
        unique case (cur_state)
            ST_IDLE: if (start_ev) next_state = ST_RUN;
            ST_RUN: begin
                load_disp = 1'b1;
                if (start_ev) begin
                    next_state = ST_STOP;
                end else if (lap_ev) begin
                    push_req   = 1'b1;
                    next_state = ST_SPLIT;
                end else if (saturated) begin
                    next_state = ST_STOP;
                end
            end
            ST_SPLIT: begin
                if (start_ev) begin
                    next_state = ST_RUN;
                end else if (lap_ev) begin
                    push_req  = 1'b1;
                    load_disp = 1'b1;
                end else if (saturated) begin
                    load_disp  = 1'b1;
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (start_ev) begin
                    next_state = ST_RUN;
                end else if (lap_ev) begin
                    flush      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state   <= ST_IDLE;
            timer_clear <= 1'b1;
            disp_q      <= '0;
        end else begin
            cur_state   <= next_state;
            timer_clear <= (next_state == ST_IDLE);
            if (next_state == ST_IDLE) begin
                disp_q <= '0;
            end else if (load_disp) begin
                disp_q <= snap;
            end
        end
    end

    assign state        = cur_state;
    assign disp_minute  = disp_q.minute;
    assign disp_second  = disp_q.second;
    assign disp_msecond = disp_q.msecond;

`ifdef STOPWATCH_CTRL_LAP_FIFO_EN
    localparam int AW = $clog2(LAP_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(LAP_DEPTH);

    snapshot_t     lap_mem [LAP_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, do_pop, do_push;

    assign lap_count = wr_ptr - rd_ptr;
    assign lap_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (lap_count == FULL_COUNT);
    assign do_pop    = lap_valid & lap_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push_req & (~fifo_full | do_pop);
    assign lap_data  = lap_valid ? lap_mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && fifo_full && !do_pop) lap_overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) lap_mem[wr_ptr[AW-1:0]] <= snap;
    end
`else
    logic unused_fifo;

    assign lap_valid    = 1'b0;
    assign lap_count    = '0;
    assign lap_overflow = 1'b0;
    assign lap_data     = '0;
    assign unused_fifo  = ^{lap_ready, push_req, flush};
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a spec-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_stopwatch_ctrl;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
`ifdef STOPWATCH_CTRL_LAP_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_RUN = 1, S_SPLIT = 2, S_STOP = 3;

    logic        clk, rst, btn_start, btn_lap, lap_ready;
    logic [7:0]  t_minute, t_second;
    logic [15:0] t_msecond;
    logic        timer_clear, lap_valid, lap_overflow;
    logic [7:0]  disp_minute, disp_second;
    logic [15:0] disp_msecond;
    logic [1:0]  state;
    logic [31:0] lap_data;
    logic [2:0]  lap_count;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .LAP_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_lap      (btn_lap),
        .t_minute     (t_minute),
        .t_second     (t_second),
        .t_msecond    (t_msecond),
        .timer_clear  (timer_clear),
        .disp_minute  (disp_minute),
        .disp_second  (disp_second),
        .disp_msecond (disp_msecond),
        .state        (state),
        .lap_valid    (lap_valid),
        .lap_ready    (lap_ready),
        .lap_data     (lap_data),
        .lap_count    (lap_count),
        .lap_overflow (lap_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A press is accepted once the raw level has differed from the accepted level
    // for DEB consecutive cycles; its pulse then appears 4 cycles after the last
    // counted cycle (2 sync + 1 accept + 1 edge detect), and the FSM reacts at the
    // edge closing the pulse cycle.
    int          cyc = 0;
    bit          m_valid = 1'b0;
    int          m_state;
    bit          m_clear, m_ovf;
    logic [31:0] m_disp, m_snap;
    logic [31:0] m_q[$];
    bit          acc[2], raw[2];
    int          run[2], due[2];
    bit          ev_start, ev_lap, m_sat, m_pop, m_push, m_flush;
    int          m_next;

    always @(posedge clk) begin
        if (!rst) begin
            m_state = S_IDLE;
            m_clear = 1'b1;
            m_disp  = '0;
            m_ovf   = 1'b0;
            m_q.delete();
            for (int b = 0; b < 2; b++) begin
                acc[b] = 1'b0;
                run[b] = 0;
                due[b] = -1;
            end
            m_valid = 1'b1;
        end else begin
            ev_start = (due[0] == cyc);
            ev_lap   = (due[1] == cyc) && !ev_start;
            raw[0]   = btn_start;
            raw[1]   = btn_lap;
            for (int b = 0; b < 2; b++) begin
                if (raw[b] != acc[b]) begin
                    run[b]++;
                    if (run[b] == DEB) begin
                        acc[b] = raw[b];
                        run[b] = 0;
                        if (raw[b]) due[b] = cyc + 4;
                    end
                end else begin
                    run[b] = 0;
                end
            end

            m_snap  = {t_minute, t_second, t_msecond};
            m_sat   = (t_minute == 8'd59);
            m_pop   = FIFO_EN && (m_q.size() > 0) && lap_ready;
            m_push  = 1'b0;
            m_flush = 1'b0;
            m_next  = m_state;
            case (m_state)
                S_IDLE:  if (ev_start) m_next = S_RUN;
                S_RUN:   if (ev_start) m_next = S_STOP;
                         else if (ev_lap) begin m_push = 1'b1; m_next = S_SPLIT; end
                         else if (m_sat) m_next = S_STOP;
                S_SPLIT: if (ev_start) m_next = S_RUN;
                         else if (ev_lap) m_push = 1'b1;
                         else if (m_sat) m_next = S_STOP;
                default: if (ev_start) m_next = S_RUN;
                         else if (ev_lap) begin m_flush = 1'b1; m_next = S_IDLE; end
            endcase

            // Live in RUN; freezes take the event-cycle snapshot; IDLE shows zero.
            if (m_next == S_IDLE) m_disp = '0;
            else if (m_state == S_RUN || m_push || (m_state == S_SPLIT && m_next == S_STOP)) m_disp = m_snap;

            if (m_flush) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push && FIFO_EN) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_snap);
                    else m_ovf = 1'b1;
                end
            end
            m_state = m_next;
            m_clear = (m_next == S_IDLE);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("state", 32'(state), 32'(m_state));
            check("timer_clear", 32'(timer_clear), 32'(m_clear));
            check("display", {disp_minute, disp_second, disp_msecond}, m_disp);
            check("lap_valid", 32'(lap_valid), 32'(m_q.size() > 0));
            check("lap_count", 32'(lap_count), 32'(m_q.size()));
            check("lap_data", lap_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
            check("lap_overflow", 32'(lap_overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int m, input int s, input int ms);
        t_minute  = 8'(m);
        t_second  = 8'(s);
        t_msecond = 16'(ms);
    endtask

    // Holds the button(s) 8 cycles then releases for 8; the pulse lands in cycle 7.
    task automatic press(input bit s, input bit l, input int ready_at);
        for (int i = 0; i < 16; i++) begin
            btn_start = s && (i < 8);
            btn_lap   = l && (i < 8);
            if (ready_at >= 0) lap_ready = (i == ready_at);
            step();
        end
    endtask

    initial begin
        rst = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; lap_ready = 1'b0;
        set_time(0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_clear", 32'(timer_clear), 32'd1);
        check("rst_disp", {disp_minute, disp_second, disp_msecond}, 32'd0);
        check("rst_count", 32'(lap_count), 32'd0);
        check("rst_ovf", 32'(lap_overflow), 32'd0);
        step();
        rst = 1'b1;
        repeat (3) step();

        // Idle to run: pulse in cycle 7, RUN in cycle 8, display live one cycle later.
        set_time(5, 12, 345);
        btn_start = 1'b1;
        repeat (7) step();
        @(negedge clk);
        check("start_c7_state", 32'(state), 32'd0);
        check("start_c7_clear", 32'(timer_clear), 32'd1);
        step();
        @(negedge clk);
        check("start_c8_state", 32'(state), 32'd1);
        check("start_c8_clear", 32'(timer_clear), 32'd0);
        step();
        @(negedge clk);
        check("run_disp", {disp_minute, disp_second, disp_msecond}, {8'd5, 8'd12, 16'd345});
        step();
        btn_start = 1'b0;
        t_msecond = 16'd346;
        step();
        @(negedge clk);
        check("run_disp_live", {disp_minute, disp_second, disp_msecond}, {8'd5, 8'd12, 16'd346});
        repeat (10) step();

        // Split at 00:03:250, input advances while the display holds.
        set_time(0, 3, 250);
        press(1'b0, 1'b1, -1);
        set_time(0, 4, 0);
        step();
        @(negedge clk);
        check("split_state", 32'(state), 32'd2);
        check("split_disp", {disp_minute, disp_second, disp_msecond}, {8'd0, 8'd3, 16'd250});
        check("split_valid", 32'(lap_valid), 32'(FIFO_EN));
        check("split_data", lap_data, FIFO_EN ? 32'h000300FA : 32'd0);
        step();
        press(1'b1, 1'b0, -1);
        t_msecond = 16'd5;
        step();
        @(negedge clk);
        check("resume_state", 32'(state), 32'd1);
        check("resume_disp", {disp_minute, disp_second, disp_msecond}, {8'd0, 8'd4, 16'd5});
        step();

        // Drain the split entry, then five laps into a 4-deep FIFO.
        lap_ready = 1'b1;
        step();
        lap_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_time(1, i, 100 * i);
            press(1'b0, 1'b1, -1);
        end
        @(negedge clk);
        check("full_count", 32'(lap_count), FIFO_EN ? 32'd4 : 32'd0);
        check("full_ovf", 32'(lap_overflow), 32'(FIFO_EN));
        step();
        lap_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("drain_data", lap_data, FIFO_EN ? {8'd1, 8'(i), 16'(100 * i)} : 32'd0);
        end
        @(negedge clk);
        check("drain_empty", 32'(lap_valid), 32'd0);
        step();
        lap_ready = 1'b0;

        // One more entry, then RUN -> STOP (frozen) -> IDLE flushes everything.
        set_time(0, 5, 0);
        press(1'b0, 1'b1, -1);
        press(1'b1, 1'b0, -1);
        set_time(0, 7, 777);
        press(1'b1, 1'b0, -1);
        set_time(0, 8, 0);
        step();
        @(negedge clk);
        check("stop_state", 32'(state), 32'd3);
        check("stop_disp", {disp_minute, disp_second, disp_msecond}, {8'd0, 8'd7, 16'd777});
        step();
        press(1'b0, 1'b1, -1);
        @(negedge clk);
        check("clear_state", 32'(state), 32'd0);
        check("clear_tclr", 32'(timer_clear), 32'd1);
        check("clear_disp", {disp_minute, disp_second, disp_msecond}, 32'd0);
        check("clear_count", 32'(lap_count), 32'd0);
        check("clear_ovf", 32'(lap_overflow), 32'd0);
        step();

        // Fill again, then push while popping at full: count holds, no overflow.
        press(1'b1, 1'b0, -1);
        for (int i = 1; i <= 4; i++) begin
            set_time(2, i, i);
            press(1'b0, 1'b1, -1);
        end
        set_time(2, 5, 5);
        press(1'b0, 1'b1, 7);
        @(negedge clk);
        check("pushpop_count", 32'(lap_count), FIFO_EN ? 32'd4 : 32'd0);
        check("pushpop_ovf", 32'(lap_overflow), 32'd0);
        check("pushpop_head", lap_data, FIFO_EN ? {8'd2, 8'd2, 16'd2} : 32'd0);
        step();

        // Start and lap together in RUN: start wins, nothing pushed.
        press(1'b1, 1'b0, -1);
        press(1'b1, 1'b1, -1);
        @(negedge clk);
        check("simul_state", 32'(state), 32'd3);
        check("simul_count", 32'(lap_count), FIFO_EN ? 32'd4 : 32'd0);
        step();

        // Two-cycle glitch is rejected.
        btn_start = 1'b1;
        repeat (2) step();
        btn_start = 1'b0;
        repeat (12) step();
        @(negedge clk);
        check("glitch_state", 32'(state), 32'd3);
        step();

        // Saturation in RUN, then start at minute 59 ends back in STOP.
        press(1'b1, 1'b0, -1);
        t_minute = 8'd59;
        @(negedge clk);
        check("sat_before", 32'(state), 32'd1);
        @(negedge clk);
        check("sat_after", 32'(state), 32'd3);
        step();
        press(1'b1, 1'b0, -1);
        @(negedge clk);
        check("sat_restart", 32'(state), 32'd3);
        step();

        // Reset mid-debounce with two entries held.
        lap_ready = 1'b1;
        repeat (2) step();
        lap_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_count", 32'(lap_count), FIFO_EN ? 32'd2 : 32'd0);
        step();
        t_minute = 8'd0;
        btn_start = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        btn_start = 1'b0;
        lap_ready = 1'b1;
        step();
        @(negedge clk);
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_clear", 32'(timer_clear), 32'd1);
        check("rst2_disp", {disp_minute, disp_second, disp_msecond}, 32'd0);
        check("rst2_valid", 32'(lap_valid), 32'd0);
        check("rst2_count", 32'(lap_count), 32'd0);
        check("rst2_ovf", 32'(lap_overflow), 32'd0);
        check("rst2_data", lap_data, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        lap_ready = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
